// File: rtl/inst_rom_bridge_pkg.sv
// Shared definitions for the instruction-fetch bridge: bus widths matching the
// core's bus macros, the 2-bit bridge state encoding, and a stall helper.
package inst_rom_bridge_pkg;

  // Core bus widths (address, data, byte-select).
  localparam int ADDR_BUS_W    = 32;
  localparam int DATA_BUS_W    = 32;
  localparam int MEM_SEL_BUS_W = 4;

  typedef logic [1:0] irb_state_t;

  // Bridge state encoding.
  localparam irb_state_t IRB_IDLE  = 2'b00;
  localparam irb_state_t IRB_REQ   = 2'b01;
  localparam irb_state_t IRB_RESP  = 2'b10;
  localparam irb_state_t IRB_DRAIN = 2'b11;

  // The PC may only advance when no word is outstanding, or when the
  // outstanding word is arriving on this very cycle.
  function automatic logic irb_stall(input irb_state_t st, input logic rvalid);
    logic s;
    case (st)
      IRB_IDLE: s = 1'b0;
      IRB_RESP: s = !rvalid;
      default:  s = 1'b1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/inst_rom_bridge.sv
// Instruction-fetch responder: turns the PC stage's combinational fetch port
// into req/gnt/rvalid bus transactions, stalls the PC until the word for the
// current pc arrives, and drops responses orphaned by a flush redirect.
module inst_rom_bridge
  import inst_rom_bridge_pkg::*;
#(
  parameter int ADDR_W = ADDR_BUS_W,
  parameter int DATA_W = DATA_BUS_W,
  parameter int SEL_W  = MEM_SEL_BUS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rom_addr,
  input  logic [SEL_W-1:0]  rom_write_en,
  input  logic [DATA_W-1:0] rom_write_data,
  input  logic              flush,
  output logic [DATA_W-1:0] rom_read_data,
  output logic              stall_req,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [SEL_W-1:0]  mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  irb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [SEL_W-1:0]  req_we_q, req_we_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
  logic [DATA_W-1:0] data_q;

  logic deliver;
  logic issue_new;

  // Stall, delivery and "present the PC stage's request on the bus now"
  // decisions. A flush while still ungranted retargets the open request;
  // a flush while waiting for data cannot, so it is handled via DRAIN.
  always_comb begin
    stall_req = irb_stall(state_q, mem_rvalid);
    deliver   = (state_q == IRB_RESP) && mem_rvalid;
    issue_new = !rst && (!stall_req || (flush && (state_q == IRB_REQ)));
  end

  // Bus request and fetched-word outputs; the arriving word bypasses data_q.
  always_comb begin
    mem_req   = 1'b0;
    mem_addr  = req_addr_q;
    mem_we    = req_we_q;
    mem_wdata = req_wdata_q;
    if (issue_new) begin
      mem_req   = 1'b1;
      mem_addr  = rom_addr;
      mem_we    = rom_write_en;
      mem_wdata = rom_write_data;
    end else if (!rst && (state_q == IRB_REQ)) begin
      mem_req = 1'b1;
    end
    rom_read_data = deliver ? mem_rdata : data_q;
  end

  // Next state and request capture.
  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_we_d    = req_we_q;
    req_wdata_d = req_wdata_q;
    if (issue_new) begin
      state_d     = mem_gnt ? IRB_RESP : IRB_REQ;
      req_addr_d  = rom_addr;
      req_we_d    = rom_write_en;
      req_wdata_d = rom_write_data;
    end else begin
      case (state_q)
        IRB_REQ: begin
          if (mem_gnt) state_d = IRB_RESP;
        end
        IRB_RESP: begin
          // Only reached without rvalid; the in-flight word is now stale.
          if (flush) begin
            state_d     = IRB_DRAIN;
            req_addr_d  = rom_addr;
            req_we_d    = rom_write_en;
            req_wdata_d = rom_write_data;
          end
        end
        IRB_DRAIN: begin
          if (flush) begin
            req_addr_d  = rom_addr;
            req_we_d    = rom_write_en;
            req_wdata_d = rom_write_data;
          end
          if (mem_rvalid) state_d = IRB_REQ;
        end
        default: state_d = IRB_IDLE;
      endcase
    end
  end

  // State, request and last-fetched-word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IRB_IDLE;
      req_addr_q  <= '0;
      req_we_q    <= '0;
      req_wdata_q <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_we_q    <= req_we_d;
      req_wdata_q <= req_wdata_d;
      if (deliver) data_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_inst_rom_bridge.sv
// Bench for inst_rom_bridge: a PC-stage model, a configurable-latency memory,
// a scoreboard of granted fetches, a vector table of fetch latencies, and
// hand-written flush / write / reset sequences.
module tb_inst_rom_bridge;

  logic        clk;
  logic        rst;
  logic [31:0] rom_addr;
  logic [3:0]  rom_write_en;
  logic [31:0] rom_write_data;
  logic        flush;
  logic [31:0] rom_read_data;
  logic        stall_req;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  inst_rom_bridge dut (
    .clk(clk), .rst(rst),
    .rom_addr(rom_addr), .rom_write_en(rom_write_en), .rom_write_data(rom_write_data),
    .flush(flush), .rom_read_data(rom_read_data), .stall_req(stall_req),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] P_IDLE = 2'd0, P_REQ = 2'd1, P_RESP = 2'd2, P_DRAIN = 2'd3;

  typedef struct { logic [31:0] addr; logic [31:0] data; logic orphan; } exp_t;
  typedef struct { logic [31:0] data; int unsigned due; } pend_t;
  typedef struct { logic [31:0] addr; int g; int r; int stalls; logic [31:0] data; } vec_t;

  int n_chk = 0;
  int n_err = 0;

  // stimulus controls
  logic        rst_now = 1'b1, flush_now = 1'b0;
  logic [31:0] flush_tgt = '0, wd_now = '0;
  logic [3:0]  we_now = '0;

  // PC stage model
  logic [31:0] pc = '0, fetch_addr = '0;

  // memory model
  pend_t       pend[$];
  int          cfg_g[16];
  int          cfg_r[16];
  int          nreq = 0, hold = 0, rvl = 1;
  logic        waiting = 1'b0;
  int unsigned cyc = 0;

  // reference model / scoreboard
  exp_t        exp_q[$];
  logic [1:0]  ph = P_IDLE;
  logic [31:0] iss_addr = '0, iss_wdata = '0, exp_dq = '0;
  logic [3:0]  iss_we = '0;

  // observations
  logic        delivered = 1'b0, last_stall = 1'b0;
  logic [31:0] last_mem_addr = '0, last_rrd = '0, dl_pc = '0, dl_data = '0;
  int          stall_cnt = 0, dl_stalls = 0;
  int          g18 = 0, g200 = 0, g100 = 0, drained = 0, saw_dead = 0;
  logic [3:0]  gnt_we40 = '0;
  logic [31:0] gnt_wd40 = '0;

  vec_t vecs[6];

  function automatic logic [31:0] golden(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h00A0_0093;
    if (a == 32'h0000_0204) return 32'hDEAD_BEEF;
    return 32'h0000_0013 | (a << 20);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // One clock cycle: drive inputs, let the memory answer, check, advance models.
  task automatic cycle();
    logic        rv, es, acc, ereq;
    logic [31:0] ea, ewd;
    logic [3:0]  ewe;
    exp_t        e;
    @(negedge clk);
    rst            = rst_now;
    flush          = flush_now;
    rom_addr       = flush_now ? flush_tgt : fetch_addr;
    rom_write_en   = we_now;
    rom_write_data = wd_now;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = pend[0].data;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
    end
    #1;
    if (mem_req && !waiting) begin
      hold = cfg_g[nreq];
      rvl  = cfg_r[nreq];
      nreq++;
    end
    mem_gnt = mem_req && (hold == 0);
    #1;
    rv            = mem_rvalid;
    last_mem_addr = mem_addr;
    last_stall    = stall_req;
    last_rrd      = rom_read_data;
    delivered     = 1'b0;
    if (rst_now) begin
      chk("mem_req_in_rst", 32'(mem_req), 32'd0);
      ph = P_IDLE; exp_dq = '0; exp_q.delete();
      iss_addr = '0; iss_we = '0; iss_wdata = '0;
    end else begin
      es   = (ph == P_REQ) || (ph == P_DRAIN) || (ph == P_RESP && !rv);
      acc  = !es || (flush_now && ph == P_REQ);
      ereq = acc || (ph == P_REQ);
      ea   = acc ? rom_addr : iss_addr;
      ewe  = acc ? rom_write_en : iss_we;
      ewd  = acc ? rom_write_data : iss_wdata;
      chk("stall_req", 32'(stall_req), 32'(es));
      chk("mem_req", 32'(mem_req), 32'(ereq));
      if (ereq) begin
        chk("mem_addr", mem_addr, ea);
        chk("mem_we", 32'(mem_we), 32'(ewe));
        chk("mem_wdata", mem_wdata, ewd);
      end
      if (stall_req) stall_cnt++;
      if (!stall_req && rom_read_data == 32'hDEAD_BEEF) saw_dead++;
      if (ph == P_RESP && rv) begin
        if (exp_q.size() == 0) chk("resp_without_request", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("rom_read_data", rom_read_data, e.data);
          chk("word_matches_pc", pc, e.addr);
          chk("not_orphan", 32'(e.orphan), 32'd0);
          exp_dq = e.data; dl_pc = pc; dl_data = rom_read_data;
          dl_stalls = stall_cnt; stall_cnt = 0; delivered = 1'b1;
        end
      end else begin
        chk("rom_read_data_hold", rom_read_data, exp_dq);
      end
      if (ph == P_DRAIN && rv) begin
        if (exp_q.size() == 0) chk("drain_without_request", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("orphan_discarded", 32'(e.orphan), 32'd1);
          drained++;
        end
      end
      if (ph == P_RESP && !rv && flush_now && exp_q.size() > 0) exp_q[0].orphan = 1'b1;
      if (mem_req && mem_gnt) begin
        exp_q.push_back('{addr: ea, data: golden(ea), orphan: 1'b0});
        if (ea == 32'h18)  g18++;
        if (ea == 32'h200) g200++;
        if (ea == 32'h100) g100++;
        if (ea == 32'h40) begin gnt_we40 = mem_we; gnt_wd40 = mem_wdata; end
      end
      if (acc) begin
        ph = mem_gnt ? P_RESP : P_REQ;
        iss_addr = rom_addr; iss_we = rom_write_en; iss_wdata = rom_write_data;
      end else begin
        case (ph)
          P_REQ: if (mem_gnt) ph = P_RESP;
          P_RESP: if (flush_now) begin
            ph = P_DRAIN;
            iss_addr = rom_addr; iss_we = rom_write_en; iss_wdata = rom_write_data;
          end
          P_DRAIN: begin
            if (flush_now) begin
              iss_addr = rom_addr; iss_we = rom_write_en; iss_wdata = rom_write_data;
            end
            if (rv) ph = P_REQ;
          end
          default: ph = P_IDLE;
        endcase
      end
      if (!es || flush_now) begin pc = rom_addr; fetch_addr = rom_addr + 32'd4; end
    end
    if (mem_req && mem_gnt) pend.push_back('{data: golden(mem_addr), due: cyc + rvl});
    if (mem_req && !mem_gnt && hold > 0) hold--;
    waiting = mem_req && !mem_gnt;
    if (rv && pend.size() > 0) pend.delete(0);
    cyc++;
  endtask

  task automatic wait_delivery(input string name);
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (delivered) break;
    end
    if (!delivered) chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; rom_addr = '0; rom_write_en = '0; rom_write_data = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 16; i++) begin cfg_g[i] = 0; cfg_r[i] = 1; end

    //            addr   gnt rv stalls data
    vecs[0] = '{32'h00, 0, 1, 0, 32'h0000_0013};
    vecs[1] = '{32'h04, 0, 1, 0, 32'h0040_0013};
    vecs[2] = '{32'h08, 3, 1, 3, 32'h0080_0013};
    vecs[3] = '{32'h0C, 0, 4, 3, 32'h00A0_0093};
    vecs[4] = '{32'h10, 0, 1, 0, 32'h0100_0013};
    vecs[5] = '{32'h14, 1, 2, 2, 32'h0140_0013};
    for (int i = 0; i < 6; i++) begin cfg_g[i] = vecs[i].g; cfg_r[i] = vecs[i].r; end
    cfg_g[6] = 3;  cfg_r[6] = 1;   // 0x18 redirected to 0x200 while ungranted
    cfg_g[7] = 0;  cfg_r[7] = 3;   // 0x204, orphaned by flush to 0x100
    cfg_g[8] = 0;  cfg_r[8] = 1;   // 0x100
    cfg_g[9] = 2;  cfg_r[9] = 2;   // 0x104 redirected to write at 0x40
    cfg_g[10] = 0; cfg_r[10] = 2;  // 0x44, interrupted by reset
    cfg_g[11] = 1; cfg_r[11] = 1;  // 0x48 after reset

    rst_now = 1'b1;
    cycle();
    cycle();
    rst_now = 1'b0;
    cycle();
    chk("reset_stall_req", 32'(last_stall), 32'd0);
    chk("reset_rom_read_data", last_rrd, 32'd0);
    chk("reset_first_addr", last_mem_addr, 32'd0);

    for (int i = 0; i < 6; i++) begin
      wait_delivery("vec");
      chk("vec_pc", dl_pc, vecs[i].addr);
      chk("vec_data", dl_data, vecs[i].data);
      chk("vec_stalls", 32'(dl_stalls), 32'(vecs[i].stalls));
    end

    // flush while the 0x18 request is still ungranted
    cycle();
    flush_now = 1'b1; flush_tgt = 32'h200;
    cycle();
    flush_now = 1'b0;
    chk("flush_req_same_cycle_addr", last_mem_addr, 32'h200);
    wait_delivery("flush_req");
    chk("flush_req_pc", dl_pc, 32'h200);
    chk("flush_req_stalls", 32'(dl_stalls), 32'd3);

    // flush while waiting for 0x204's data
    flush_now = 1'b1; flush_tgt = 32'h100;
    cycle();
    flush_now = 1'b0;
    wait_delivery("flush_resp");
    chk("flush_resp_pc", dl_pc, 32'h100);
    chk("flush_resp_data", dl_data, 32'h1000_0013);
    chk("flush_resp_stalls", 32'(dl_stalls), 32'd4);

    // write to 0x40 injected by redirecting the ungranted 0x104 request
    cycle();
    flush_now = 1'b1; flush_tgt = 32'h40; we_now = 4'hF; wd_now = 32'h1234_5678;
    cycle();
    flush_now = 1'b0; we_now = 4'h0; wd_now = '0;
    wait_delivery("write");
    chk("write_pc", dl_pc, 32'h40);
    chk("write_stalls", 32'(dl_stalls), 32'd3);
    chk("write_gnt_we", 32'(gnt_we40), 32'hF);
    chk("write_gnt_wdata", gnt_wd40, 32'h1234_5678);

    // reset while the 0x44 response is outstanding; it lands in IDLE
    rst_now = 1'b1;
    cycle();
    rst_now = 1'b0;
    cycle();
    chk("late_rvalid_stall", 32'(last_stall), 32'd0);
    chk("late_rvalid_data", last_rrd, 32'd0);
    wait_delivery("after_reset");
    chk("after_reset_pc", dl_pc, 32'h48);
    chk("after_reset_data", dl_data, 32'h0480_0013);

    chk("grants_0x18", 32'(g18), 32'd0);
    chk("grants_0x200", 32'(g200), 32'd1);
    chk("grants_0x100", 32'(g100), 32'd1);
    chk("orphans_drained", 32'(drained), 32'd1);
    chk("stale_word_seen", 32'(saw_dead), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
